// File: rtl/seg_reg_bank_pkg.sv
// Shared CPU constants for the pipeline front end: reset PC, bubble instruction,
// default control-bundle width and a saturating counter helper.
package seg_reg_bank_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] CPU_NOP_INST = 32'h0000_0013;
  localparam int          CPU_CTRL_W   = 16;
  localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

  // Counters stick at CNT_MAX instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != CNT_MAX)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/seg_reg_bank_seg_reg.sv
// Generic pipeline stage register: flush beats stall, stall beats load.
// Reset is applied by the parent as a flush with the reset value.
module seg_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  input  logic [W-1:0] flush_val,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = d;
    if (flush) begin
      q_d = flush_val;
    end else if (stall) begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seg_reg_bank.sv
// PC, IF/ID and ID/EX pipeline registers with stall/flush control and
// saturating stall/flush event counters.
module seg_reg_bank
  import seg_reg_bank_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter logic [31:0] NOP_INST = CPU_NOP_INST,
  parameter int          CTRL_W   = CPU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              stall_if2id,
  input  logic              flush_if2id,
  input  logic              flush_id2ex,
  input  logic [31:0]       npc,
  input  logic [31:0]       inst_if,
  input  logic [CTRL_W-1:0] ctrl_id,
  output logic [31:0]       pc,
  output logic [31:0]       pc_id,
  output logic [31:0]       inst_id,
  output logic              valid_id,
  output logic [31:0]       pc_ex,
  output logic [31:0]       inst_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              valid_ex,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  localparam int IFID_W = 32 + 32 + 1;
  localparam int IDEX_W = 32 + 32 + CTRL_W + 1;

  logic [IFID_W-1:0] ifid_d, ifid_bubble, ifid_q;
  logic [IDEX_W-1:0] idex_d, idex_bubble, idex_q;
  logic [31:0]       stall_cnt_d, stall_cnt_q;
  logic [31:0]       flush_cnt_d, flush_cnt_q;

  // Reset rides on the flush path so every stage register shares one priority rule.
  seg_reg #(.W(32)) u_pc_reg (
    .clk       (clk),
    .stall     (stall_pc),
    .flush     (rst),
    .d         (npc),
    .flush_val (RESET_PC),
    .q         (pc)
  );

  assign ifid_d      = {pc, inst_if, 1'b1};
  assign ifid_bubble = {32'd0, NOP_INST, 1'b0};

  seg_reg #(.W(IFID_W)) u_ifid_reg (
    .clk       (clk),
    .stall     (stall_if2id),
    .flush     (flush_if2id | rst),
    .d         (ifid_d),
    .flush_val (ifid_bubble),
    .q         (ifid_q)
  );

  assign pc_id    = ifid_q[IFID_W-1 -: 32];
  assign inst_id  = ifid_q[32:1];
  assign valid_id = ifid_q[0];

  // A bubble zeroes the control bundle so no write enable can leak into EX.
  assign idex_d      = {pc_id, inst_id, ctrl_id, valid_id};
  assign idex_bubble = {32'd0, NOP_INST, {CTRL_W{1'b0}}, 1'b0};

  seg_reg #(.W(IDEX_W)) u_idex_reg (
    .clk       (clk),
    .stall     (1'b0),
    .flush     (flush_id2ex | rst),
    .d         (idex_d),
    .flush_val (idex_bubble),
    .q         (idex_q)
  );

  assign pc_ex    = idex_q[IDEX_W-1 -: 32];
  assign inst_ex  = idex_q[IDEX_W-33 -: 32];
  assign ctrl_ex  = idex_q[CTRL_W:1];
  assign valid_ex = idex_q[0];

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, stall_pc);
    flush_cnt_d = sat_inc(flush_cnt_q, flush_if2id);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_seg_reg_bank.sv
// Directed self-checking bench for seg_reg_bank: reset, straight-line flow,
// load-use stall, branch flush, stall/flush conflict, saturation, reset mid-stall.
module tb_seg_reg_bank;

  logic        clk;
  logic        rst;
  logic        stall_pc;
  logic        stall_if2id;
  logic        flush_if2id;
  logic        flush_id2ex;
  logic [31:0] npc;
  logic [31:0] inst_if;
  logic [15:0] ctrl_id;
  logic [31:0] pc;
  logic [31:0] pc_id;
  logic [31:0] inst_id;
  logic        valid_id;
  logic [31:0] pc_ex;
  logic [31:0] inst_ex;
  logic [15:0] ctrl_ex;
  logic        valid_ex;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int testsRun  = 0;
  int testsFail = 0;

  seg_reg_bank dut (
    .clk         (clk),
    .rst         (rst),
    .stall_pc    (stall_pc),
    .stall_if2id (stall_if2id),
    .flush_if2id (flush_if2id),
    .flush_id2ex (flush_id2ex),
    .npc         (npc),
    .inst_if     (inst_if),
    .ctrl_id     (ctrl_id),
    .pc          (pc),
    .pc_id       (pc_id),
    .inst_id     (inst_id),
    .valid_id    (valid_id),
    .pc_ex       (pc_ex),
    .inst_ex     (inst_ex),
    .ctrl_ex     (ctrl_ex),
    .valid_ex    (valid_ex),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, take the rising edge, then settle 1 time unit past it.
  task automatic applyStimulus(input logic r, input logic spc, input logic sif,
                               input logic fif, input logic fex, input logic [31:0] n,
                               input logic [31:0] inst, input logic [15:0] ctrl);
    rst         = r;
    stall_pc    = spc;
    stall_if2id = sif;
    flush_if2id = fif;
    flush_id2ex = fex;
    npc         = n;
    inst_if     = inst;
    ctrl_id     = ctrl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " pc"},        pc,               32'h0000_3000);
    checkOutput({tag, " pc_id"},     pc_id,            32'h0);
    checkOutput({tag, " inst_id"},   inst_id,          32'h13);
    checkOutput({tag, " valid_id"},  {31'd0, valid_id}, 32'd0);
    checkOutput({tag, " pc_ex"},     pc_ex,            32'h0);
    checkOutput({tag, " inst_ex"},   inst_ex,          32'h13);
    checkOutput({tag, " ctrl_ex"},   {16'd0, ctrl_ex}, 32'd0);
    checkOutput({tag, " valid_ex"},  {31'd0, valid_ex}, 32'd0);
    checkOutput({tag, " stall_cnt"}, stall_cnt,        32'd0);
    checkOutput({tag, " flush_cnt"}, flush_cnt,        32'd0);
  endtask

  initial begin
    // Reset for two edges with stall/flush also asserted: reset must win.
    applyStimulus(1, 1, 1, 1, 1, 32'h0000_4444, 32'hDEAD_BEEF, 16'hFFFF);
    applyStimulus(1, 1, 0, 1, 0, 32'h0000_4444, 32'hDEAD_BEEF, 16'hFFFF);
    checkResetState("reset");

    // First normal edge fetches from 0x3000.
    applyStimulus(0, 0, 0, 0, 0, 32'h0000_3004, 32'h0050_0093, 16'h0000);
    checkOutput("flow1 pc",       pc,                32'h0000_3004);
    checkOutput("flow1 pc_id",    pc_id,             32'h0000_3000);
    checkOutput("flow1 inst_id",  inst_id,           32'h0050_0093);
    checkOutput("flow1 valid_id", {31'd0, valid_id}, 32'd1);
    checkOutput("flow1 valid_ex", {31'd0, valid_ex}, 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 32'h0000_3008, 32'h00A0_0113, 16'h0081);
    checkOutput("flow2 pc",       pc,                32'h0000_3008);
    checkOutput("flow2 pc_id",    pc_id,             32'h0000_3004);
    checkOutput("flow2 pc_ex",    pc_ex,             32'h0000_3000);
    checkOutput("flow2 inst_ex",  inst_ex,           32'h0050_0093);
    checkOutput("flow2 ctrl_ex",  {16'd0, ctrl_ex},  32'h0000_0081);
    checkOutput("flow2 valid_ex", {31'd0, valid_ex}, 32'd1);

    // Load-use stall at pc 0x3008.
    applyStimulus(0, 1, 1, 0, 1, 32'h0000_300C, 32'h0020_8193, 16'h00FF);
    checkOutput("lduse pc",        pc,                32'h0000_3008);
    checkOutput("lduse pc_id",     pc_id,             32'h0000_3004);
    checkOutput("lduse inst_id",   inst_id,           32'h00A0_0113);
    checkOutput("lduse valid_id",  {31'd0, valid_id}, 32'd1);
    checkOutput("lduse pc_ex",     pc_ex,             32'h0);
    checkOutput("lduse inst_ex",   inst_ex,           32'h13);
    checkOutput("lduse ctrl_ex",   {16'd0, ctrl_ex},  32'd0);
    checkOutput("lduse valid_ex",  {31'd0, valid_ex}, 32'd0);
    checkOutput("lduse stall_cnt", stall_cnt,         32'd1);
    checkOutput("lduse flush_cnt", flush_cnt,         32'd0);

    // Stall released: the held instruction moves on.
    applyStimulus(0, 0, 0, 0, 0, 32'h0000_300C, 32'h0020_8193, 16'h0042);
    checkOutput("resume pc",       pc,                32'h0000_300C);
    checkOutput("resume pc_id",    pc_id,             32'h0000_3008);
    checkOutput("resume inst_id",  inst_id,           32'h0020_8193);
    checkOutput("resume pc_ex",    pc_ex,             32'h0000_3004);
    checkOutput("resume inst_ex",  inst_ex,           32'h00A0_0113);
    checkOutput("resume ctrl_ex",  {16'd0, ctrl_ex},  32'h0000_0042);
    checkOutput("resume valid_ex", {31'd0, valid_ex}, 32'd1);

    // Taken branch: redirect and bubble both stages together.
    applyStimulus(0, 0, 0, 1, 1, 32'h0000_3100, 32'hDEAD_BEEF, 16'hFFFF);
    checkOutput("branch pc",        pc,                32'h0000_3100);
    checkOutput("branch pc_id",     pc_id,             32'h0);
    checkOutput("branch inst_id",   inst_id,           32'h13);
    checkOutput("branch valid_id",  {31'd0, valid_id}, 32'd0);
    checkOutput("branch inst_ex",   inst_ex,           32'h13);
    checkOutput("branch ctrl_ex",   {16'd0, ctrl_ex},  32'd0);
    checkOutput("branch valid_ex",  {31'd0, valid_ex}, 32'd0);
    checkOutput("branch flush_cnt", flush_cnt,         32'd1);
    checkOutput("branch stall_cnt", stall_cnt,         32'd1);

    applyStimulus(0, 0, 0, 0, 0, 32'h0000_3104, 32'h0000_0033, 16'h0000);
    checkOutput("target pc_id",   pc_id,   32'h0000_3100);
    checkOutput("target inst_id", inst_id, 32'h0000_0033);

    // Stall and flush of IF/ID together: flush wins, PC stall still honoured.
    applyStimulus(0, 1, 1, 1, 0, 32'h0000_3108, 32'h1111_1111, 16'h0003);
    checkOutput("conflict pc",        pc,                32'h0000_3104);
    checkOutput("conflict inst_id",   inst_id,           32'h13);
    checkOutput("conflict valid_id",  {31'd0, valid_id}, 32'd0);
    checkOutput("conflict pc_ex",     pc_ex,             32'h0000_3100);
    checkOutput("conflict inst_ex",   inst_ex,           32'h0000_0033);
    checkOutput("conflict ctrl_ex",   {16'd0, ctrl_ex},  32'h0000_0003);
    checkOutput("conflict stall_cnt", stall_cnt,         32'd2);
    checkOutput("conflict flush_cnt", flush_cnt,         32'd2);

    // Preload the stall counter just below the limit, then stall three cycles.
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    applyStimulus(0, 1, 0, 0, 0, 32'h0000_3108, 32'h0000_0000, 16'h0000);
    checkOutput("sat1 stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 0, 0, 0, 32'h0000_3108, 32'h0000_0000, 16'h0000);
    checkOutput("sat2 stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 0, 0, 0, 32'h0000_3108, 32'h0000_0000, 16'h0000);
    checkOutput("sat3 stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    checkOutput("sat3 pc",        pc,        32'h0000_3104);
    checkOutput("sat3 flush_cnt", flush_cnt, 32'd2);

    // Reset during an active stall discards everything in flight.
    applyStimulus(1, 1, 1, 0, 1, 32'h0000_3108, 32'h2222_2222, 16'h0007);
    checkResetState("rststall");

    applyStimulus(0, 0, 0, 0, 0, 32'h0000_3004, 32'h0050_0093, 16'h0000);
    checkOutput("post-rst pc",       pc,                32'h0000_3004);
    checkOutput("post-rst pc_id",    pc_id,             32'h0000_3000);
    checkOutput("post-rst valid_id", {31'd0, valid_id}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/seg_reg_bank.md
SEG_REG_BANK -- requirements
Module: seg_reg_bank

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction word inserted as a bubble.
REQ-003 Parameter CTRL_W, default 16, width of the decoded control bundle carried ID->EX.
REQ-004 Clock is clk and reset is rst; one clock, reset synchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall_pc  in  1  hold PC.
- stall_if2id  in  1  hold IF/ID register.
- flush_if2id  in  1  bubble IF/ID register.
- flush_id2ex  in  1  bubble ID/EX register.
- npc  in  32  next PC from the next-PC mux.
- inst_if  in  32  fetched instruction for the current pc.
- ctrl_id  in  CTRL_W  decoded control bundle of the ID-stage instruction.
- pc  out  32  current fetch PC.
- pc_id, inst_id  out  32 each  IF/ID contents.
- valid_id  out  1  IF/ID holds a real instruction.
- pc_ex, inst_ex  out  32 each  ID/EX contents.
- ctrl_ex  out  CTRL_W  ID/EX control bundle.
- valid_ex  out  1  ID/EX holds a real instruction.
- stall_cnt  out  32  cycles with stall_pc high.
- flush_cnt  out  32  cycles with flush_if2id high.

Function
REQ-006 All registers SHALL update only on the rising edge of clk; outputs SHALL be driven directly from registers with no combinational path from inputs.
REQ-007 pc SHALL hold when stall_pc=1, else load npc.
REQ-008 IF/ID priority SHALL be flush_if2id > stall_if2id > normal load.
- Flush: pc_id=0, inst_id=NOP_INST, valid_id=0.
- Stall: hold all IF/ID fields.
- Normal: pc_id<=pc, inst_id<=inst_if, valid_id<=1.
REQ-009 ID/EX SHALL have no stall input. On flush_id2ex=1 it SHALL load a bubble: pc_ex=0, inst_ex=NOP_INST, ctrl_ex=0, valid_ex=0. Otherwise it SHALL load pc_id, inst_id, ctrl_id and valid_id.
REQ-010 A bubble SHALL force ctrl_ex=0 regardless of ctrl_id, so that no register-file or memory write is enabled.
REQ-011 Simultaneous load-use stall (stall_pc=stall_if2id=flush_id2ex=1) SHALL hold PC and IF/ID and insert exactly one ID/EX bubble per asserted cycle.
REQ-012 Simultaneous branch flush (flush_if2id=flush_id2ex=1, no stall) SHALL load npc into pc and bubble both IF/ID and ID/EX in the same edge.
REQ-013 If stall_if2id and flush_if2id are both high, IF/ID SHALL flush; stall_pc SHALL still be honoured independently.
REQ-014 stall_cnt SHALL increment by 1 on every edge with stall_pc=1; flush_cnt SHALL increment by 1 on every edge with flush_if2id=1.
REQ-015 Both counters SHALL saturate at 32'hFFFF_FFFF and SHALL NOT wrap.
REQ-016 Latency: an instruction fetched at edge N SHALL appear in IF/ID after edge N and in ID/EX after edge N+1, plus one edge per stalled cycle.

Reset
REQ-017 On rst=1 at an edge, regardless of every other input:
- pc=RESET_PC.
- IF/ID and ID/EX hold bubbles (valid=0, inst=NOP_INST, pc=0, ctrl_ex=0).
- stall_cnt=0 and flush_cnt=0.
REQ-018 Reset asserted mid-stall or mid-flush SHALL discard all in-flight contents; the first non-reset edge SHALL behave as a normal load from RESET_PC.

Structure
REQ-019 NOP_INST, RESET_PC default and the CTRL_W default SHALL live in the shared CPU constants package used by the decoder.
REQ-020 One sub-module, seg_reg (parameterised width, ports: stall, flush, d, flush_val, q), SHALL be instantiated per stage register; counters stay in the top module.

Verification
REQ-021 Reset: rst=1 for 2 cycles, then released -> pc=32'h3000, valid_id=valid_ex=0, inst_ex=32'h13, both counters 0; pc reads 32'h3004 after the next edge with npc=32'h3004.
REQ-022 Straight-line flow: npc=pc+4 and inst_if=32'h00500093 at pc 32'h3000 -> pc_id=32'h3000 one edge later, pc_ex=32'h3000 with valid_ex=1 two edges later.
REQ-023 Load-use: one cycle of stall_pc=stall_if2id=flush_id2ex=1 while pc=32'h3008 -> pc holds 32'h3008, IF/ID unchanged, valid_ex=0, ctrl_ex=0, stall_cnt=1.
REQ-024 Branch: flush_if2id=flush_id2ex=1 with npc=32'h3100 -> pc=32'h3100, valid_id=valid_ex=0, inst_id=inst_ex=32'h13, flush_cnt=1.
REQ-025 Conflict and saturation: stall_if2id=flush_if2id=1 -> IF/ID flushed. Counter forced near the limit (stall_cnt=32'hFFFF_FFFE) plus 3 stall cycles -> stall_cnt=32'hFFFF_FFFF.
REQ-026 Reset mid-stall: rst=1 during an active stall -> next state identical to REQ-021.
